// File: rtl/hilo_unit.sv
// HI/LO register file with a 32-step restoring divider for DIV/DIVU.
// Define HILO_BYPASS_EN to forward same-cycle ALU writes and divider results onto hi_out/lo_out.
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        flush,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_busy,
  output logic        div_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi_r, lo_r;
  logic [5:0]  count;
  logic [31:0] rem, quo, dvsr;
  logic        neg_q, neg_r;
  logic        start_ok;
  logic [31:0] abs_a, abs_b;
  logic [32:0] trial, diff;
  logic [31:0] q_fix, r_fix;

  assign start_ok = (state == IDLE) && div_start && !flush;
  // Two's-complement negation of 0x80000000 yields 0x80000000, the unsigned magnitude.
  assign abs_a    = (div_signed && div_a[31]) ? -div_a : div_a;
  assign abs_b    = (div_signed && div_b[31]) ? -div_b : div_b;
  assign trial    = {rem, quo[31]};
  assign diff     = trial - {1'b0, dvsr};
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -rem : rem;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    div_busy  = (state != IDLE);
    div_done  = (state == DONE);
    unique case (state)
      IDLE: if (start_ok) state_nxt = (div_b == 32'd0) ? DONE : BUSY;
      BUSY: begin
        if (flush)               state_nxt = IDLE;
        else if (count == 6'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r  <= '0;
      lo_r  <= '0;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (hilo_we[1]) hi_r <= hi_in;
      if (hilo_we[0]) lo_r <= lo_in;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            count <= '0;
            if (div_b == 32'd0) begin
              quo   <= '1;
              rem   <= div_a;
              dvsr  <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= abs_a;
              rem   <= '0;
              dvsr  <= abs_b;
              neg_q <= div_signed && (div_a[31] ^ div_b[31]);
              neg_r <= div_signed && div_a[31];
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            count <= count + 6'd1;
            // diff[32] is the borrow: set means the divisor did not fit.
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end
        end
        DONE: begin
          // Placed after the ALU write so the divider result takes both registers.
          if (!flush) begin
            hi_r <= r_fix;
            lo_r <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    hi_out = hilo_we[1] ? hi_in : hi_r;
    lo_out = hilo_we[0] ? lo_in : lo_r;
    if (state == DONE) begin
      hi_out = r_fix;
      lo_out = q_fix;
    end
  end
`else
  assign hi_out = hi_r;
  assign lo_out = lo_r;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: a cycle-level reference model compared every cycle,
// plus directed divide/flush/reset scenarios with literal expectations.
module tb_hilo_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hilo_we;
  logic [31:0] hi_in, lo_in;
  logic        div_start, div_signed;
  logic [31:0] div_a, div_b;
  logic        flush;
  logic [31:0] hi_out, lo_out;
  logic        div_busy, div_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk(clk), .rst(rst), .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .flush(flush), .hi_out(hi_out), .lo_out(lo_out),
    .div_busy(div_busy), .div_done(div_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quotient/remainder from plain arithmetic; returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Model: edges remaining until the divider commits (0 = idle, 1 = completion cycle).
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_remain = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi     <= '0;
      m_lo     <= '0;
      m_remain <= 0;
    end else begin
      if (hilo_we[1]) m_hi <= hi_in;
      if (hilo_we[0]) m_lo <= lo_in;
      if (m_remain > 0) begin
        if (flush) m_remain <= 0;
        else begin
          if (m_remain == 1) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
          m_remain <= m_remain - 1;
        end
      end else if (div_start && !flush) begin
        m_res    <= ref_div(div_signed, div_a, div_b);
        m_remain <= (div_b == 32'd0) ? 1 : 33;
      end
    end
  end

  always begin
    logic [31:0] exp_hi, exp_lo;
    @(posedge clk);
    #2;
    exp_hi = m_hi;
    exp_lo = m_lo;
`ifdef HILO_BYPASS_EN
    if (m_remain == 1) begin
      exp_hi = m_res[63:32];
      exp_lo = m_res[31:0];
    end else begin
      if (hilo_we[1]) exp_hi = hi_in;
      if (hilo_we[0]) exp_lo = lo_in;
    end
`endif
    check("model hi_out", hi_out, exp_hi);
    check("model lo_out", lo_out, exp_lo);
    check("model div_busy", 32'(div_busy), 32'(m_remain > 0));
    check("model div_done", 32'(div_done), 32'(m_remain == 1));
    if (div_done) done_cnt++;
  end

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (div_busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b, output int cyc);
    @(negedge clk);
    div_start = 1'b1; div_signed = sg; div_a = a; div_b = b;
    @(negedge clk);
    div_start = 1'b0;
    wait_idle(cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, d0;
    rst = 1'b1; hilo_we = 2'b00; hi_in = '0; lo_in = '0;
    div_start = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset hi_out", hi_out, 32'h0);
    check("reset lo_out", lo_out, 32'h0);
    check("reset div_busy", 32'(div_busy), 32'h0);
    check("reset div_done", 32'(div_done), 32'h0);

    // ALU write to HI only.
    hilo_we = 2'b10; hi_in = 32'h12345678; lo_in = 32'hAAAA5555;
    @(negedge clk);
    hilo_we = 2'b00;
    check("alu hi write", hi_out, 32'h12345678);
    check("alu lo untouched", lo_out, 32'h0);

    // DIVU 100/7.
    d0 = done_cnt;
    do_div(1'b0, 32'd100, 32'd7, cyc);
    check("divu stall cycles", cyc, 32'd33);
    check("divu done pulses", done_cnt - d0, 32'd1);
    check("divu lo", lo_out, 32'd14);
    check("divu hi", hi_out, 32'd2);

    // Signed divides.
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, cyc);
    check("div -7/2 lo", lo_out, 32'hFFFFFFFD);
    check("div -7/2 hi", hi_out, 32'hFFFFFFFF);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
    check("div min/-1 lo", lo_out, 32'h80000000);
    check("div min/-1 hi", hi_out, 32'h0);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, cyc);
    check("div 7/-2 lo", lo_out, 32'hFFFFFFFD);
    check("div 7/-2 hi", hi_out, 32'd1);

    // Divide by zero.
    do_div(1'b1, 32'hDEADBEEF, 32'd0, cyc);
    check("div0 stall cycles", cyc, 32'd1);
    check("div0 lo", lo_out, 32'hFFFFFFFF);
    check("div0 hi", hi_out, 32'hDEADBEEF);

    // Flush at BUSY count 5.
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(div_busy), 32'h0);
    check("flush lo kept", lo_out, 32'hFFFFFFFF);
    check("flush hi kept", hi_out, 32'hDEADBEEF);

    // Flush in IDLE blocks a simultaneous start.
    div_start = 1'b1; flush = 1'b1; div_a = 32'd5; div_b = 32'd1;
    @(negedge clk);
    div_start = 1'b0; flush = 1'b0;
    check("idle flush start ignored", 32'(div_busy), 32'h0);

    // Start during BUSY ignored; ALU write during BUSY applied.
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; div_a = 32'd100; div_b = 32'd7;
    @(negedge clk);
    div_start = 1'b0; hilo_we = 2'b10; hi_in = 32'h00000077;
    @(negedge clk);
    hilo_we = 2'b00;
    check("busy alu write", hi_out, 32'h00000077);
    div_start = 1'b1; div_a = 32'd50; div_b = 32'd5;
    @(negedge clk);
    div_start = 1'b0;
    wait_idle(cyc);
    check("busy start ignored cycles", cyc, 32'd31);
    check("busy start ignored lo", lo_out, 32'd14);
    check("busy start ignored hi", hi_out, 32'd2);

    // ALU write of both halves on the DONE edge loses to the divider.
    @(negedge clk);
    div_start = 1'b1; div_a = 32'd9; div_b = 32'd4;
    @(negedge clk);
    div_start = 1'b0;
    cyc = 0;
    while (!div_done && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("done reached", 32'(div_done), 32'h1);
    hilo_we = 2'b11; hi_in = 32'hFFFF0000; lo_in = 32'h0000FFFF;
    @(negedge clk);
    hilo_we = 2'b00;
    check("done edge lo", lo_out, 32'd2);
    check("done edge hi", hi_out, 32'd1);

    // Reset at BUSY count 10.
    @(negedge clk);
    div_start = 1'b1; div_a = 32'd12345; div_b = 32'd11;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", 32'(div_busy), 32'h0);
    check("mid reset hi", hi_out, 32'h0);
    check("mid reset lo", lo_out, 32'h0);
    repeat (40) @(negedge clk);
    check("no late write hi", hi_out, 32'h0);
    check("no late write lo", lo_out, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
